// File: rtl/cu_signal_pipeline.sv
// Registered control-word pipeline ID->EX->MEM->WB with bubble insertion,
// delay-slot annul tracking and a saturating debug bubble counter.
module cu_signal_pipeline #(
    parameter int                     CW_WIDTH  = 19,
    parameter logic [CW_WIDTH-1:0]    BUBBLE_CW = {CW_WIDTH{1'b0}},
    parameter int                     CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW_WIDTH-1:0]  id_cw,
    input  logic                 id_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 annul_req,
    input  logic                 cnt_clear,
    output logic [CW_WIDTH-1:0]  ex_cw,
    output logic [CW_WIDTH-1:0]  mem_cw,
    output logic [CW_WIDTH-1:0]  wb_cw,
    output logic                 ex_valid,
    output logic                 mem_valid,
    output logic                 wb_valid,
    output logic                 annul_pending,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        ANNUL = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CW_WIDTH-1:0]  ex_cw_q, ex_cw_d;
    logic [CW_WIDTH-1:0]  mem_cw_q, wb_cw_q;
    logic                 ex_valid_q, ex_valid_d;
    logic                 mem_valid_q, wb_valid_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic accept;
    logic squash;
    logic bubble_event;

    always_comb begin
        accept       = id_valid & ~stall;
        squash       = flush | (state_q == ANNUL);
        ex_cw_d      = BUBBLE_CW;
        ex_valid_d   = 1'b0;
        bubble_event = 1'b0;
        if (stall) begin
            bubble_event = 1'b1;
        end else if (!id_valid || squash) begin
            // Empty ID slots carry no instruction, so they are not bubbles.
            bubble_event = id_valid;
        end else begin
            ex_cw_d    = id_cw;
            ex_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (annul_req && !flush) state_d = ANNUL;
            ANNUL: if (accept || flush)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (bubble_event && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ex_cw_q     <= BUBBLE_CW;
            mem_cw_q    <= BUBBLE_CW;
            wb_cw_q     <= BUBBLE_CW;
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ex_cw_q     <= ex_cw_d;
            ex_valid_q  <= ex_valid_d;
            mem_cw_q    <= ex_cw_q;
            mem_valid_q <= ex_valid_q;
            wb_cw_q     <= mem_cw_q;
            wb_valid_q  <= mem_valid_q;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_cw         = ex_cw_q;
    assign mem_cw        = mem_cw_q;
    assign wb_cw         = wb_cw_q;
    assign ex_valid      = ex_valid_q;
    assign mem_valid     = mem_valid_q;
    assign wb_valid      = wb_valid_q;
    assign annul_pending = (state_q == ANNUL);
    assign bubble_cnt    = cnt_q;

endmodule
